uart_loop_fifo: RTL and testbench

Parametrised UART loopback: receives serial frames on `rx`, buffers good characters in an internal FIFO, and retransmits them on `tx` with the same frame format. It is the successor to the fixed 8N1 loopback. It adds:
- configurable data width, parity and stop bits;
- glitch rejection, frame and parity error detection;
- a TX pause input, with overflow reporting when the FIFO is full.

It sits between the board RS-232 pins and serves as the bring-up/echo block for host link testing.

---
 rtl/uart_loop_fifo.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_loop_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loop_fifo.sv
// UART echo block: receives framed characters on rx, queues good ones in a
// circular FIFO and retransmits them on tx in the same frame format.
module uart_loop_fifo #(
  parameter int CLK_FRE    = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_CNT = CLK_FRE / BAUD;
  localparam int HALF     = BAUD_CNT / 2;
  localparam int CW       = $clog2(BAUD_CNT + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic rx_s1, rx_s2, rx_d, rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;

  state_t                 rx_state;
  logic [CW-1:0]          rx_cnt;
  logic [3:0]             rx_bit;
  logic [DATA_BITS-1:0]   rx_data;
  logic                   rx_par, rx_stop_ok, rx_done, rx_tick;

  // The start bit is resampled half a bit in; every later sample is a full bit apart.
  assign rx_tick = (rx_state == S_START) ? (rx_cnt == CW'(HALF - 1))
                                         : (rx_cnt == CW'(BAUD_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_data    <= '0;
      rx_par     <= 1'b0;
      rx_stop_ok <= 1'b1;
      rx_done    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
            rx_bit   <= '0;
          end
        end
        S_START: begin
          if (rx_tick) begin
            rx_cnt     <= '0;
            rx_stop_ok <= 1'b1;
            rx_state   <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_cnt  <= '0;
            rx_data <= {rx_s2, rx_data[DATA_BITS-1:1]};
            if (rx_bit == 4'(DATA_BITS - 1)) begin
              rx_bit   <= '0;
              rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_par   <= rx_s2;
            rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_tick) begin
            rx_cnt     <= '0;
            rx_stop_ok <= rx_stop_ok & rx_s2;
            if (rx_bit == 4'(STOP_BITS - 1)) begin
              rx_bit   <= '0;
              rx_done  <= 1'b1;
              rx_state <= S_IDLE;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  logic par_exp, par_ok, good, wr, pop, full, empty, tx_end;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rd_data;

  always_comb begin
    par_exp = (^rx_data) ^ (PARITY == 1);
    par_ok  = (PARITY == 0) || (rx_par == par_exp);
  end

  assign full    = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (fifo_count == '0);
  assign good    = rx_done & rx_stop_ok & par_ok;
  // A full FIFO still accepts a character when TX frees a slot in the same cycle.
  assign wr      = good & (~full | pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= rx_done & ~rx_stop_ok;
      parity_err <= rx_done & rx_stop_ok & ~par_ok;
      overflow   <= good & full & ~pop;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rx_data;
  end

  state_t                 tx_state;
  logic [CW-1:0]          tx_cnt;
  logic [3:0]             tx_bit;
  logic [DATA_BITS-1:0]   tx_shift;
  logic                   tx_par, tx_bit_end;

  assign tx_bit_end = (tx_cnt == CW'(BAUD_CNT - 1));
  assign tx_end     = (tx_state == S_STOP) & tx_bit_end & (tx_bit == 4'(STOP_BITS - 1));
  // Popping on the final stop edge chains frames with no idle gap.
  assign pop        = tx_en & ~empty & ((tx_state == S_IDLE) | tx_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else if (pop) begin
      tx_state <= S_START;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= rd_data;
      tx_par   <= (^rd_data) ^ (PARITY == 1);
      tx       <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: tx <= 1'b1;
        S_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx       <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 4'(DATA_BITS - 1)) begin
              tx_bit <= '0;
              if (PARITY != 0) begin
                tx_state <= S_PARITY;
                tx       <= tx_par;
              end else begin
                tx_state <= S_STOP;
                tx       <= 1'b1;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 4'(STOP_BITS - 1)) begin
              tx_bit   <= '0;
              tx_state <= S_IDLE;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Bench for uart_loop_fifo: two instances (8N1 and 7E2, 16 clocks per bit) driven
// with serial frames; a line decoder on tx is compared against expected characters.
module tb_uart_loop_fifo;

  localparam int B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, tx_en_a = 1'b1, tx_a, fe_a, pe_a, ov_a;
  logic [2:0] cnt_a;
  logic       rx_b = 1'b1, tx_en_b = 1'b1, tx_b, fe_b, pe_b, ov_b;
  logic [2:0] cnt_b;

  uart_loop_fifo #(.CLK_FRE(160), .BAUD(10), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .tx_en(tx_en_a), .tx(tx_a),
    .frame_err(fe_a), .parity_err(pe_a), .overflow(ov_a), .fifo_count(cnt_a));

  uart_loop_fifo #(.CLK_FRE(160), .BAUD(10), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .tx_en(tx_en_b), .tx(tx_b),
    .frame_err(fe_b), .parity_err(pe_b), .overflow(ov_b), .fifo_count(cnt_b));

  int errors = 0;
  int checks = 0;
  int fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0;
  int fe_cnt_b = 0, pe_cnt_b = 0, ov_cnt_b = 0;
  int fmt_a = 0, fmt_b = 0;
  logic [7:0] got_a[$], got_b[$];
  longint fall_a[$];
  longint t_rx;

  // Count pulse cycles so that a stretched pulse shows up as a wrong count.
  always @(negedge clk) begin
    if (fe_a) fe_cnt_a++;
    if (pe_a) pe_cnt_a++;
    if (ov_a) ov_cnt_a++;
    if (fe_b) fe_cnt_b++;
    if (pe_b) pe_cnt_b++;
    if (ov_b) ov_cnt_b++;
  end

  function automatic logic txv(input int which);
    return (which == 0) ? tx_a : tx_b;
  endfunction

  task automatic decode(input int which, output logic [7:0] d, output bit ok, output bit ab);
    int nd = (which == 0) ? 8 : 7;
    int ns = (which == 0) ? 1 : 2;
    d = '0; ok = 1'b1; ab = 1'b0;
    repeat (B / 2) begin @(negedge clk); if (!rst_n) begin ab = 1'b1; return; end end
    if (txv(which) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < nd; i++) begin
      repeat (B) begin @(negedge clk); if (!rst_n) begin ab = 1'b1; return; end end
      d[i] = txv(which);
    end
    if (which == 1) begin
      repeat (B) begin @(negedge clk); if (!rst_n) begin ab = 1'b1; return; end end
      if (txv(which) !== (^d)) ok = 1'b0;
    end
    for (int s = 0; s < ns; s++) begin
      repeat (B) begin @(negedge clk); if (!rst_n) begin ab = 1'b1; return; end end
      if (txv(which) !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin : mon_a
    logic [7:0] d;
    bit ok, ab;
    longint tf;
    forever begin
      @(negedge clk);
      if (rst_n && tx_a === 1'b0) begin
        tf = $time;
        decode(0, d, ok, ab);
        if (!ab) begin
          got_a.push_back(d);
          fall_a.push_back(tf);
          if (!ok) fmt_a++;
        end
      end
    end
  end

  initial begin : mon_b
    logic [7:0] d;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (rst_n && tx_b === 1'b0) begin
        decode(1, d, ok, ab);
        if (!ab) begin
          got_b.push_back(d);
          if (!ok) fmt_b++;
        end
      end
    end
  end

  // Caller must be sitting on a negedge; frames sent back to back are contiguous.
  task automatic send_frame(input int which, input logic [7:0] d, input bit flip, input bit stop0);
    logic bits[$];
    logic [7:0] m;
    int nd = (which == 0) ? 8 : 7;
    m = (which == 0) ? d : {1'b0, d[6:0]};
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(m[i]);
    if (which == 1) bits.push_back((^m) ^ flip);
    for (int s = 0; s < ((which == 0) ? 1 : 2); s++) bits.push_back(~stop0);
    t_rx = $time;
    foreach (bits[i]) begin
      if (which == 0) rx_a = bits[i]; else rx_b = bits[i];
      repeat (B) @(negedge clk);
    end
    if (which == 0) rx_a = 1'b1; else rx_b = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (tx_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_a: got %b want 1", tx_a); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_b: got %b want 1", tx_b); end
    checks++; if (cnt_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_cnt_a: got %0d want 0", cnt_a); end
    checks++; if ({fe_a, pe_a, ov_a, fe_b, pe_b, ov_b} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_err_flags: got %b want 000000", {fe_a, pe_a, ov_a, fe_b, pe_b, ov_b});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (tx_a !== 1'b1 || cnt_a !== 3'd0) begin
      errors++; $display("[TB] FAIL post_reset_idle: tx=%b cnt=%0d want tx=1 cnt=0", tx_a, cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int base = got_a.size();
    int fe0 = fe_cnt_a, pe0 = pe_cnt_a, ov0 = ov_cnt_a, fm0 = fmt_a;
    int maxc = 0;
    longint t_first;
    for (int i = 0; i < 8; i++) exp.push_back(8'(i));
    for (int i = 0; i < 4; i++) exp.push_back(8'($urandom_range(0, 255)));
    t_first = $time;
    fork
      foreach (exp[i]) send_frame(0, exp[i], 1'b0, 1'b0);
      repeat (12 * 10 * B + 4 * B) begin
        @(negedge clk);
        if (int'(cnt_a) > maxc) maxc = int'(cnt_a);
      end
    join
    repeat (3 * 10 * B) @(negedge clk);
    checks++; if (got_a.size() - base != 12) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d chars want 12", got_a.size() - base);
    end
    foreach (exp[i]) begin
      if (got_a.size() > base + i) begin
        checks++; if (got_a[base + i] !== exp[i]) begin
          errors++; $display("[TB] FAIL b2b_char%0d: got %02h want %02h", i, got_a[base + i], exp[i]);
        end
      end
    end
    checks++; if (fmt_a != fm0) begin errors++; $display("[TB] FAIL b2b_format: got %0d bad frames want 0", fmt_a - fm0); end
    checks++; if (fe_cnt_a != fe0 || pe_cnt_a != pe0 || ov_cnt_a != ov0) begin
      errors++; $display("[TB] FAIL b2b_err_pulses: got fe=%0d pe=%0d ov=%0d want 0", fe_cnt_a - fe0, pe_cnt_a - pe0, ov_cnt_a - ov0);
    end
    checks++; if (maxc > 1) begin errors++; $display("[TB] FAIL b2b_fifo_peak: got %0d want <=1", maxc); end
    if (fall_a.size() > base) begin
      longint lat = (fall_a[base] - t_first) / 10;
      checks++; if (lat < 156 || lat > 158) begin
        errors++; $display("[TB] FAIL echo_latency: got %0d clocks want 157+-1", lat);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] r = 8'($urandom_range(0, 127));
    int base = got_b.size();
    int pe0 = pe_cnt_b, fe0 = fe_cnt_b, fm0 = fmt_b;
    send_frame(1, 8'h55, 1'b0, 1'b0);
    send_frame(1, r, 1'b0, 1'b0);
    send_frame(1, 8'h55, 1'b1, 1'b0);
    repeat (3 * 11 * B) @(negedge clk);
    checks++; if (got_b.size() - base != 2) begin
      errors++; $display("[TB] FAIL parity_echo_count: got %0d want 2", got_b.size() - base);
    end
    if (got_b.size() >= base + 2) begin
      checks++; if (got_b[base] !== 8'h55 || got_b[base + 1] !== r) begin
        errors++; $display("[TB] FAIL parity_echo_data: got %02h %02h want 55 %02h", got_b[base], got_b[base + 1], r);
      end
    end
    checks++; if (pe_cnt_b - pe0 != 1) begin errors++; $display("[TB] FAIL parity_err_pulse: got %0d cycles want 1", pe_cnt_b - pe0); end
    checks++; if (fe_cnt_b != fe0 || fmt_b != fm0) begin
      errors++; $display("[TB] FAIL parity_side_effects: got fe=%0d badfmt=%0d want 0", fe_cnt_b - fe0, fmt_b - fm0);
    end
  endtask

  task automatic test_frame_err();
    int base = got_a.size();
    int fe0 = fe_cnt_a, pe0 = pe_cnt_a;
    int lows = 0, maxc = 0;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1);
      repeat (10 * B + 20) begin
        @(negedge clk);
        if (tx_a !== 1'b1) lows++;
        if (int'(cnt_a) > maxc) maxc = int'(cnt_a);
      end
    join
    repeat (2 * B) @(negedge clk);
    checks++; if (fe_cnt_a - fe0 != 1) begin errors++; $display("[TB] FAIL frame_err_pulse: got %0d cycles want 1", fe_cnt_a - fe0); end
    checks++; if (pe_cnt_a != pe0) begin errors++; $display("[TB] FAIL frame_err_parity: got %0d want 0", pe_cnt_a - pe0); end
    checks++; if (maxc != 0 || lows != 0 || got_a.size() != base) begin
      errors++; $display("[TB] FAIL frame_err_no_echo: got fifo_peak=%0d tx_low=%0d chars=%0d want 0 0 0", maxc, lows, got_a.size() - base);
    end
  endtask

  task automatic test_glitch();
    int base = got_a.size();
    int fe0 = fe_cnt_a, pe0 = pe_cnt_a, ov0 = ov_cnt_a;
    logic [7:0] r = 8'($urandom_range(0, 255));
    rx_a = 1'b0;
    repeat (B / 4) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * B) @(negedge clk);
    checks++; if (got_a.size() != base || cnt_a !== 3'd0 || tx_a !== 1'b1) begin
      errors++; $display("[TB] FAIL glitch_ignored: got chars=%0d cnt=%0d tx=%b want 0 0 1", got_a.size() - base, cnt_a, tx_a);
    end
    checks++; if (fe_cnt_a != fe0 || pe_cnt_a != pe0 || ov_cnt_a != ov0) begin
      errors++; $display("[TB] FAIL glitch_errs: got fe=%0d pe=%0d ov=%0d want 0", fe_cnt_a - fe0, pe_cnt_a - pe0, ov_cnt_a - ov0);
    end
    send_frame(0, r, 1'b0, 1'b0);
    repeat (2 * 10 * B) @(negedge clk);
    checks++; if (got_a.size() != base + 1 || (got_a.size() == base + 1 && got_a[base] !== r)) begin
      errors++; $display("[TB] FAIL glitch_recover: got %0d chars want 1 of %02h", got_a.size() - base, r);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    int base = got_a.size();
    int ov0 = ov_cnt_a;
    tx_en_a = 1'b0;
    for (int i = 0; i < 5; i++) exp.push_back(8'($urandom_range(0, 255)));
    foreach (exp[i]) send_frame(0, exp[i], 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (cnt_a !== 3'd4) begin errors++; $display("[TB] FAIL ovf_full_count: got %0d want 4", cnt_a); end
    checks++; if (ov_cnt_a - ov0 != 1) begin errors++; $display("[TB] FAIL ovf_pulse: got %0d cycles want 1", ov_cnt_a - ov0); end
    checks++; if (got_a.size() != base) begin errors++; $display("[TB] FAIL ovf_paused_tx: got %0d chars want 0", got_a.size() - base); end
    tx_en_a = 1'b1;
    repeat (5 * 10 * B) @(negedge clk);
    checks++; if (cnt_a !== 3'd0) begin errors++; $display("[TB] FAIL ovf_drain_count: got %0d want 0", cnt_a); end
    checks++; if (got_a.size() - base != 4) begin errors++; $display("[TB] FAIL ovf_drain_chars: got %0d want 4", got_a.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (got_a.size() > base + i) begin
        checks++; if (got_a[base + i] !== exp[i]) begin
          errors++; $display("[TB] FAIL ovf_char%0d: got %02h want %02h", i, got_a[base + i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    int base;
    tx_en_a = 1'b0;
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    send_frame(0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    tx_en_a = 1'b1;
    repeat (2 * B + B / 2) @(negedge clk);
    checks++; if (tx_a !== 1'b0 || cnt_a !== 3'd1) begin
      errors++; $display("[TB] FAIL midtx_precond: got tx=%b cnt=%0d want 0 1", tx_a, cnt_a);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1 || cnt_a !== 3'd0) begin
      errors++; $display("[TB] FAIL midtx_async_reset: got tx=%b cnt=%0d want 1 0", tx_a, cnt_a);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = got_a.size();
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    repeat (2 * 10 * B) @(negedge clk);
    checks++; if (got_a.size() != base + 1 || (got_a.size() == base + 1 && got_a[base] !== 8'h3C)) begin
      errors++; $display("[TB] FAIL midtx_fresh_echo: got %0d chars want one 3c", got_a.size() - base);
    end
    checks++; if (cnt_a !== 3'd0 || tx_a !== 1'b1) begin
      errors++; $display("[TB] FAIL midtx_final_idle: got cnt=%0d tx=%b want 0 1", cnt_a, tx_a);
    end
  endtask

  initial begin : watchdog
    #(500_000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_glitch();
    test_overflow();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
